seq_shifter: RTL and testbench

- Multi-cycle, handshaked successor to the combinational SHL datapath component. It is generalised to five shift/rotate modes and to arbitrary power-of-two widths.
- Internally it is an iterative barrel shifter. It resolves one binary digit of the shift amount per clock, giving log2(DATAWIDTH) cycles of work.
- Used by HLS-generated datapaths where a full-width combinational barrel shifter would break timing. The scheduler treats it as a multi-cycle resource with valid/ready.

---
 rtl/seq_shifter_pkg.sv | 16 +
 rtl/seq_shifter_if.sv | 27 ++
 rtl/seq_shifter_shift_step.sv | 35 +++
 rtl/seq_shifter.sv | 109 ++++++++++
 tb/tb_seq_shifter.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/seq_shifter_pkg.sv
// Shared encodings for the iterative shift/rotate unit: operation modes and FSM states.
package seq_shifter_pkg;

    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_SHL = 3'd0;
    localparam logic [MODE_W-1:0] MODE_SHR = 3'd1;
    localparam logic [MODE_W-1:0] MODE_SRA = 3'd2;
    localparam logic [MODE_W-1:0] MODE_ROL = 3'd3;
    localparam logic [MODE_W-1:0] MODE_ROR = 3'd4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/seq_shifter_if.sv
// Request/response bundle of the shifter; the requester uses master, the shifter uses slave.
interface seq_shifter_if
    import seq_shifter_pkg::*;
#(
    parameter int DATAWIDTH = 8
);
    // A transfer happens on a rising edge where valid and ready are both high;
    // the sender holds its payload stable while valid is high and ready is low.
    logic [DATAWIDTH-1:0] a;
    logic [DATAWIDTH-1:0] sh_amt;
    logic [MODE_W-1:0]    mode;
    logic                 in_valid;
    logic                 in_ready;
    logic [DATAWIDTH-1:0] d;
    logic                 out_valid;
    logic                 out_ready;

    modport master (
        output a, sh_amt, mode, in_valid, out_ready,
        input  in_ready, d, out_valid
    );

    modport slave (
        input  a, sh_amt, mode, in_valid, out_ready,
        output in_ready, d, out_valid
    );
endinterface

// File: rtl/seq_shifter_shift_step.sv
// One stage of the iterative barrel shifter: optionally shift/rotate a value by one power-of-two distance.
module shift_step
    import seq_shifter_pkg::*;
#(
    parameter int DATAWIDTH = 8
) (
    input  logic [DATAWIDTH-1:0] i_value,
    input  logic [DATAWIDTH-1:0] i_distance,
    input  logic                 i_enable,
    input  logic [MODE_W-1:0]    i_mode,
    input  logic                 i_sign,
    output logic [DATAWIDTH-1:0] o_value
);
    logic [2*DATAWIDTH-1:0] w_dbl_l;
    logic [2*DATAWIDTH-1:0] w_dbl_r;
    logic [2*DATAWIDTH-1:0] w_sra;

    // Rotates shift a doubled copy so the wrapped bits land in the kept half.
    always_comb begin
        w_dbl_l = {i_value, i_value} << i_distance;
        w_dbl_r = {i_value, i_value} >> i_distance;
        w_sra   = {{DATAWIDTH{i_sign}}, i_value} >> i_distance;
        o_value = i_value;
        if (i_enable) begin
            case (i_mode)
                MODE_SHL: o_value = i_value << i_distance;
                MODE_SHR: o_value = i_value >> i_distance;
                MODE_SRA: o_value = w_sra[DATAWIDTH-1:0];
                MODE_ROL: o_value = w_dbl_l[2*DATAWIDTH-1:DATAWIDTH];
                MODE_ROR: o_value = w_dbl_r[DATAWIDTH-1:0];
                default:  o_value = i_value;
            endcase
        end
    end
endmodule

// File: rtl/seq_shifter.sv
// Handshaked multi-cycle shifter: resolves one bit of the shift amount per clock.
module seq_shifter
    import seq_shifter_pkg::*;
#(
    parameter int  DATAWIDTH = 8,
    localparam int NSTG      = $clog2(DATAWIDTH),
    localparam int CW        = (NSTG > 1) ? $clog2(NSTG) : 1
) (
    input  logic            Clk,
    input  logic            Rst_n,
    seq_shifter_if.slave    bus,
    output logic [1:0]      o_dbg_state,
    output logic [CW-1:0]   o_dbg_cnt
);
    if ((DATAWIDTH < 2) || ((DATAWIDTH & (DATAWIDTH - 1)) != 0)) begin : g_bad_width
        $error("seq_shifter: DATAWIDTH must be a power of two and at least 2");
    end

    localparam logic [CW-1:0] LAST = CW'(NSTG - 1);

    logic [1:0]           r_state;
    logic [CW-1:0]        r_cnt;
    logic [DATAWIDTH-1:0] r_work;
    logic [NSTG-1:0]      r_amt;
    logic [MODE_W-1:0]    r_mode;
    logic                 r_ovf;
    logic                 r_sign;
    logic [DATAWIDTH-1:0] r_d;
    logic                 r_out_valid;

    logic [DATAWIDTH-1:0] w_dist;
    logic                 w_enable;
    logic [DATAWIDTH-1:0] w_step;
    logic [DATAWIDTH-1:0] w_result;

    assign w_dist   = {{(DATAWIDTH-1){1'b0}}, 1'b1} << r_cnt;
    assign w_enable = r_amt[r_cnt];

    shift_step #(.DATAWIDTH(DATAWIDTH)) u_step (
        .i_value    (r_work),
        .i_distance (w_dist),
        .i_enable   (w_enable),
        .i_mode     (r_mode),
        .i_sign     (r_sign),
        .o_value    (w_step)
    );

    // Amounts of DATAWIDTH or more saturate shifts; rotates keep the mod-width result.
    always_comb begin
        w_result = w_step;
        case (r_mode)
            MODE_SHL, MODE_SHR: if (r_ovf) w_result = '0;
            MODE_SRA:           if (r_ovf) w_result = {DATAWIDTH{r_sign}};
            default:            w_result = w_step;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_work      <= '0;
            r_amt       <= '0;
            r_mode      <= '0;
            r_ovf       <= 1'b0;
            r_sign      <= 1'b0;
            r_d         <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_work  <= bus.a;
                        r_amt   <= bus.sh_amt[NSTG-1:0];
                        r_mode  <= bus.mode;
                        r_ovf   <= |bus.sh_amt[DATAWIDTH-1:NSTG];
                        r_sign  <= bus.a[DATAWIDTH-1];
                        r_cnt   <= '0;
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_work <= w_step;
                    if (r_cnt == LAST) begin
                        r_cnt       <= '0;
                        r_d         <= w_result;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = r_out_valid;
    assign bus.d         = r_d;
    assign o_dbg_state   = r_state;
    assign o_dbg_cnt     = r_cnt;
endmodule

// File: tb/tb_seq_shifter.sv
// Directed bench for seq_shifter at DATAWIDTH=8: queued expectations checked by an output monitor.
module tb_seq_shifter;
    import seq_shifter_pkg::*;

    localparam int W = 8;

    logic       Clk;
    logic       Rst_n;
    logic [1:0] dbg_state;
    logic [1:0] dbg_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    logic [W-1:0] exp_q[$];

    seq_shifter_if #(.DATAWIDTH(W)) bus ();

    seq_shifter #(.DATAWIDTH(W)) dut (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .bus         (bus),
        .o_dbg_state (dbg_state),
        .o_dbg_cnt   (dbg_cnt)
    );

    // clock / reset
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // scoreboard monitor: one compare per output handshake
    always @(negedge Clk) begin
        if (Rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_result: got 0x%0h expected none", bus.d);
            end else begin
                check("result", 32'(bus.d), 32'(exp_q.pop_front()));
            end
        end
    end

    // driver tasks: called and returning at 1 time unit after a rising edge
    task automatic issue(input logic [2:0] m, input logic [W-1:0] av,
                         input logic [W-1:0] sv, input logic [W-1:0] ev);
        int t = 0;
        while (!bus.in_ready && t < 50) begin
            @(posedge Clk); #1;
            t++;
        end
        if (!bus.in_ready) begin
            n_checks++;
            $display("FAIL accept_timeout: in_ready stayed 0 required 1");
        end
        bus.a        = av;
        bus.sh_amt   = sv;
        bus.mode     = m;
        bus.in_valid = 1'b1;
        exp_q.push_back(ev);
        @(posedge Clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(posedge Clk); #1;
            t++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain_timeout: %0d results outstanding required 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge Clk); #1;
    endtask

    initial begin
        Rst_n         = 1'b0;
        bus.a         = '0;
        bus.sh_amt    = '0;
        bus.mode      = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_d", 32'(bus.d), 32'h0);
        check("rst_state", 32'(dbg_state), 32'(S_IDLE));
        check("rst_cnt", 32'(dbg_cnt), 32'd0);
        @(negedge Clk) Rst_n = 1'b1;
        @(posedge Clk); #1;

        // latency of a single SHL
        issue(MODE_SHL, 8'h81, 8'd1, 8'h02);
        check("lat_t0_in_ready", 32'(bus.in_ready), 32'd0);
        check("lat_t0_state", 32'(dbg_state), 32'(S_BUSY));
        @(posedge Clk); #1;
        check("lat_t1_out_valid", 32'(bus.out_valid), 32'd0);
        @(posedge Clk); #1;
        check("lat_t2_out_valid", 32'(bus.out_valid), 32'd0);
        check("lat_t2_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge Clk); #1;
        check("lat_t3_out_valid", 32'(bus.out_valid), 32'd1);
        check("lat_t3_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge Clk); #1;
        check("lat_t4_out_valid", 32'(bus.out_valid), 32'd0);
        check("lat_t4_in_ready", 32'(bus.in_ready), 32'd1);
        drain();

        // directed vectors, issued back to back
        issue(MODE_SRA, 8'h90, 8'd2,  8'hE4);
        issue(MODE_SHR, 8'h90, 8'd2,  8'h24);
        issue(MODE_ROL, 8'h81, 8'd9,  8'h03);
        issue(MODE_ROR, 8'h01, 8'd1,  8'h80);
        issue(MODE_ROR, 8'hB4, 8'd3,  8'h96);
        issue(MODE_SHR, 8'hFF, 8'd8,  8'h00);
        issue(MODE_SRA, 8'h80, 8'hFF, 8'hFF);
        issue(MODE_SHL, 8'h01, 8'h10, 8'h00);
        issue(MODE_SHL, 8'hA5, 8'd0,  8'hA5);
        issue(3'd5,     8'h5A, 8'd3,  8'h5A);
        issue(3'd7,     8'hC3, 8'hFF, 8'hC3);
        drain();

        // backpressure: hold out_ready low, poke in_valid meanwhile
        bus.out_ready = 1'b0;
        issue(MODE_SHL, 8'h0F, 8'd4, 8'hF0);
        for (int t = 0; t < 20 && !bus.out_valid; t++) begin
            @(posedge Clk); #1;
        end
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_d", 32'(bus.d), 32'hF0);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            bus.a        = 8'h33;
            bus.sh_amt   = 8'd1;
            bus.mode     = MODE_SHL;
            bus.in_valid = 1'b1;
            @(posedge Clk); #1;
        end
        bus.in_valid = 1'b0;
        check("bp_still_valid", 32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1;
        @(posedge Clk); #1;
        check("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
        check("bp_release_out_valid", 32'(bus.out_valid), 32'd0);
        check("bp_queue_empty", 32'(exp_q.size()), 32'd0);
        repeat (6) @(posedge Clk);
        #1;
        check("bp_no_extra_accept", 32'(dbg_state), 32'(S_IDLE));

        // asynchronous reset in the middle of BUSY
        bus.a        = 8'h01;
        bus.sh_amt   = 8'd3;
        bus.mode     = MODE_SHL;
        bus.in_valid = 1'b1;
        @(posedge Clk); #1;
        bus.in_valid = 1'b0;
        @(posedge Clk); #1;
        check("mid_cnt", 32'(dbg_cnt), 32'd1);
        Rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(bus.out_valid), 32'd0);
        check("arst_d", 32'(bus.d), 32'h0);
        check("arst_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge Clk);
        @(negedge Clk) Rst_n = 1'b1;
        @(posedge Clk); #1;
        issue(MODE_SHL, 8'h01, 8'd7, 8'h80);
        drain();
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
